rob_alloc_commit: RTL and testbench

- Reorder buffer: the producer side of the register-alias-table protocol.
- Allocates ROB tags (physical addresses) to renamed instructions and captures execution writeback.
- Retires entries in program order and drives the commit/flush signals the alias table consumes.
- Sits between rename/dispatch, the execution units and the architectural register file.

---
 rtl/rob_alloc_commit.sv | 192 +++++++++++++++++++
 tb/tb_rob_alloc_commit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_alloc_commit.sv
// rob_alloc_commit: in-order reorder buffer.
// Grants tail tags to renamed instructions and records execution writeback.
// Retires the head entry once it is done, and flushes the whole buffer when a
// retiring entry carries a branch redirect or an exception.
module rob_alloc_commit #(
  parameter int ROB_DEPTH      = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  // rename / dispatch side
  input  logic                         alloc_req,
  input  logic [GPR_ADDR_WIDTH-1:0]    alloc_dst_addr,
  input  logic                         alloc_dst_wen,
  output logic                         allocate_en,
  output logic [$clog2(ROB_DEPTH)-1:0] rob_alloc_tag_2rat,
  output logic [GPR_ADDR_WIDTH-1:0]    rob_alloc_dst_addr_2rat,
  output logic                         rob_alloc_dst_wen_2rat,
  output logic                         rob_full,
  output logic                         rob_empty,
  // execution writeback
  input  logic                         wb_en,
  input  logic [$clog2(ROB_DEPTH)-1:0] wb_tag,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         wb_br_taken,
  input  logic                         wb_exp,
  // operand bypass lookup
  input  logic [$clog2(ROB_DEPTH)-1:0] rd_tag,
  output logic                         rd_done,
  output logic [DATA_WIDTH-1:0]        rd_data,
  // retirement
  output logic                         commit_dst_en,
  output logic [GPR_ADDR_WIDTH-1:0]    rob_commit_dst_addr_2rat,
  output logic [$clog2(ROB_DEPTH)-1:0] rob_commit_Paddr,
  output logic [DATA_WIDTH-1:0]        rob_commit_data,
  output logic                         rob_commit_br_taken,
  output logic                         rob_commit_exp_en
);

  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam int PTR_W = TAG_W + 1;
  localparam logic [PTR_W-1:0]     PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]     PTR_ONE   = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [ROB_DEPTH-1:0] ENT_ZERO  = {ROB_DEPTH{1'b0}};
  localparam logic [TAG_W-1:0]     TAG_ZERO  = {TAG_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [GPR_ADDR_WIDTH-1:0] GPR_ZERO = {GPR_ADDR_WIDTH{1'b0}};

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  // when the indices coincide.
  logic [PTR_W-1:0]          head_r;
  logic [PTR_W-1:0]          tail_r;

  // Per-entry status flags, one bit per entry.
  logic [ROB_DEPTH-1:0]      valid_r;
  logic [ROB_DEPTH-1:0]      done_r;
  logic [ROB_DEPTH-1:0]      dst_wen_r;
  logic [ROB_DEPTH-1:0]      br_taken_r;
  logic [ROB_DEPTH-1:0]      exp_r;

  // Per-entry payload.
  logic [GPR_ADDR_WIDTH-1:0] dst_addr_r [ROB_DEPTH];
  logic [DATA_WIDTH-1:0]     data_r     [ROB_DEPTH];

  logic [TAG_W-1:0]          head_idx_s;
  logic [TAG_W-1:0]          tail_idx_s;
  logic                      full_s;
  logic                      empty_s;
  logic                      commit_valid_s;
  logic                      commit_exp_s;
  logic                      commit_br_s;
  logic                      flush_s;
  logic                      alloc_fire_s;
  logic                      wb_hit_s;

  // Decode pointer state into status, retirement and flush conditions.
  always_comb begin
    head_idx_s     = head_r[TAG_W-1:0];
    tail_idx_s     = tail_r[TAG_W-1:0];
    full_s         = (head_idx_s == tail_idx_s) && (head_r[TAG_W] != tail_r[TAG_W]);
    empty_s        = (head_r == tail_r);
    commit_valid_s = valid_r[head_idx_s] & done_r[head_idx_s];
    // An exception outranks a branch redirect on the same retiring entry.
    commit_exp_s   = commit_valid_s & exp_r[head_idx_s];
    commit_br_s    = commit_valid_s & br_taken_r[head_idx_s] & ~exp_r[head_idx_s];
    flush_s        = commit_exp_s | commit_br_s;
    // Full refuses allocation even if the head retires on the same edge.
    alloc_fire_s   = alloc_req & ~full_s & ~flush_s;
    // Writeback to an entry not currently valid is dropped; this also drops
    // a writeback aimed at the slot being allocated on the same edge.
    wb_hit_s       = wb_en & valid_r[wb_tag];
  end

  // Drive the allocation, bypass and retirement outputs.
  always_comb begin
    allocate_en             = alloc_fire_s;
    rob_alloc_tag_2rat      = tail_idx_s;
    rob_alloc_dst_addr_2rat = alloc_dst_addr;
    rob_alloc_dst_wen_2rat  = alloc_dst_wen;
    rob_full                = full_s;
    rob_empty               = empty_s;
    rd_done                 = valid_r[rd_tag] & done_r[rd_tag];
    rd_data                 = data_r[rd_tag];
    rob_commit_br_taken     = commit_br_s;
    rob_commit_exp_en       = commit_exp_s;
    commit_dst_en           = 1'b0;
    rob_commit_Paddr        = TAG_ZERO;
    rob_commit_dst_addr_2rat = GPR_ZERO;
    rob_commit_data         = DATA_ZERO;
    if (commit_valid_s) begin
      // A faulting instruction must not update architectural state.
      commit_dst_en            = dst_wen_r[head_idx_s] & ~exp_r[head_idx_s];
      rob_commit_Paddr         = head_idx_s;
      rob_commit_dst_addr_2rat = dst_addr_r[head_idx_s];
      rob_commit_data          = data_r[head_idx_s];
    end else begin
      commit_dst_en            = 1'b0;
      rob_commit_Paddr         = TAG_ZERO;
      rob_commit_dst_addr_2rat = GPR_ZERO;
      rob_commit_data          = DATA_ZERO;
    end
  end

  // Advance head on retirement and tail on allocation; a flush rewinds both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= PTR_ZERO;
      tail_r <= PTR_ZERO;
    end else if (flush_s) begin
      head_r <= PTR_ZERO;
      tail_r <= PTR_ZERO;
    end else begin
      if (commit_valid_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (alloc_fire_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
    end
  end

  // Maintain per-entry status flags: writeback, retirement and allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= ENT_ZERO;
      done_r     <= ENT_ZERO;
      dst_wen_r  <= ENT_ZERO;
      br_taken_r <= ENT_ZERO;
      exp_r      <= ENT_ZERO;
    end else if (flush_s) begin
      // Same-edge writeback and allocation are discarded along with the flush.
      valid_r <= ENT_ZERO;
      done_r  <= ENT_ZERO;
    end else begin
      if (wb_hit_s) begin
        done_r[wb_tag]     <= 1'b1;
        br_taken_r[wb_tag] <= wb_br_taken;
        exp_r[wb_tag]      <= wb_exp;
      end
      if (commit_valid_s) begin
        valid_r[head_idx_s] <= 1'b0;
      end
      // Allocation is applied last so it wins over anything else on its slot.
      if (alloc_fire_s) begin
        valid_r[tail_idx_s]    <= 1'b1;
        done_r[tail_idx_s]     <= 1'b0;
        dst_wen_r[tail_idx_s]  <= alloc_dst_wen;
        br_taken_r[tail_idx_s] <= 1'b0;
        exp_r[tail_idx_s]      <= 1'b0;
      end
    end
  end

  // Capture payload: destination at allocation, result at writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        dst_addr_r[i] <= GPR_ZERO;
        data_r[i]     <= DATA_ZERO;
      end
    end else if (!flush_s) begin
      if (wb_hit_s) begin
        data_r[wb_tag] <= wb_data;
      end
      if (alloc_fire_s) begin
        dst_addr_r[tail_idx_s] <= alloc_dst_addr;
      end
    end
  end

endmodule

// File: tb/tb_rob_alloc_commit.sv
// tb_rob_alloc_commit: directed test-plan sequence followed by random traffic,
// all checked every cycle against a queue-based program-order model.
module tb_rob_alloc_commit;

  localparam int D  = 8;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic [AW-1:0] alloc_dst_addr;
  logic          alloc_dst_wen;
  logic          allocate_en;
  logic [TW-1:0] rob_alloc_tag_2rat;
  logic [AW-1:0] rob_alloc_dst_addr_2rat;
  logic          rob_alloc_dst_wen_2rat;
  logic          rob_full;
  logic          rob_empty;
  logic          wb_en;
  logic [TW-1:0] wb_tag;
  logic [DW-1:0] wb_data;
  logic          wb_br_taken;
  logic          wb_exp;
  logic [TW-1:0] rd_tag;
  logic          rd_done;
  logic [DW-1:0] rd_data;
  logic          commit_dst_en;
  logic [AW-1:0] rob_commit_dst_addr_2rat;
  logic [TW-1:0] rob_commit_Paddr;
  logic [DW-1:0] rob_commit_data;
  logic          rob_commit_br_taken;
  logic          rob_commit_exp_en;

  always #5 clk = ~clk;

  rob_alloc_commit #(.ROB_DEPTH(D), .DATA_WIDTH(DW), .GPR_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_dst_addr(alloc_dst_addr), .alloc_dst_wen(alloc_dst_wen),
    .allocate_en(allocate_en), .rob_alloc_tag_2rat(rob_alloc_tag_2rat),
    .rob_alloc_dst_addr_2rat(rob_alloc_dst_addr_2rat), .rob_alloc_dst_wen_2rat(rob_alloc_dst_wen_2rat),
    .rob_full(rob_full), .rob_empty(rob_empty),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .wb_br_taken(wb_br_taken), .wb_exp(wb_exp),
    .rd_tag(rd_tag), .rd_done(rd_done), .rd_data(rd_data),
    .commit_dst_en(commit_dst_en), .rob_commit_dst_addr_2rat(rob_commit_dst_addr_2rat),
    .rob_commit_Paddr(rob_commit_Paddr), .rob_commit_data(rob_commit_data),
    .rob_commit_br_taken(rob_commit_br_taken), .rob_commit_exp_en(rob_commit_exp_en)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order model: oldest instruction at the front of the queue.
  typedef struct {
    int            tag;
    logic [AW-1:0] dst;
    logic          wen;
    logic          done;
    logic [DW-1:0] data;
    logic          br;
    logic          exp;
  } ent_t;

  ent_t rob_q[$];
  int   next_tag = 0;

  // Compare every output against the model mid-cycle, then advance the model
  // by the edge that follows.
  always @(negedge clk) begin : compare
    ent_t h;
    ent_t e;
    logic cv, exp_en, br_en, flush, alloc_ok, rdd;
    logic [DW-1:0] rdv;
    if (rst) begin
      rob_q.delete();
      next_tag = 0;
    end
    if (rob_q.size() > 0) h = rob_q[0];
    else h = '{default: 0};
    cv       = (rob_q.size() > 0) && h.done;
    exp_en   = cv && h.exp;
    br_en    = cv && h.br && !h.exp;
    flush    = exp_en || br_en;
    alloc_ok = alloc_req && (rob_q.size() < D) && !flush;
    rdd = 1'b0;
    rdv = '0;
    foreach (rob_q[i]) begin
      if (rob_q[i].tag == int'(rd_tag)) begin
        rdd = rob_q[i].done;
        rdv = rob_q[i].data;
      end
    end
    chk("allocate_en", allocate_en, alloc_ok);
    chk("alloc_tag", rob_alloc_tag_2rat, next_tag);
    chk("alloc_dst_pass", rob_alloc_dst_addr_2rat, alloc_dst_addr);
    chk("alloc_wen_pass", rob_alloc_dst_wen_2rat, alloc_dst_wen);
    chk("rob_full", rob_full, rob_q.size() == D);
    chk("rob_empty", rob_empty, rob_q.size() == 0);
    chk("commit_dst_en", commit_dst_en, cv && h.wen && !h.exp);
    chk("commit_paddr", rob_commit_Paddr, cv ? h.tag : 0);
    chk("commit_dst_addr", rob_commit_dst_addr_2rat, cv ? h.dst : 5'd0);
    chk("commit_data", rob_commit_data, cv ? h.data : 32'd0);
    chk("commit_br", rob_commit_br_taken, br_en);
    chk("commit_exp", rob_commit_exp_en, exp_en);
    chk("rd_done", rd_done, rdd);
    if (rdd) chk("rd_data", rd_data, rdv);
    if (!rst) begin
      if (flush) begin
        rob_q.delete();
        next_tag = 0;
      end else begin
        if (wb_en) begin
          foreach (rob_q[i]) begin
            if (rob_q[i].tag == int'(wb_tag)) begin
              rob_q[i].done = 1'b1;
              rob_q[i].data = wb_data;
              rob_q[i].br   = wb_br_taken;
              rob_q[i].exp  = wb_exp;
            end
          end
        end
        if (cv) void'(rob_q.pop_front());
        if (alloc_ok) begin
          e = '{tag: next_tag, dst: alloc_dst_addr, wen: alloc_dst_wen, done: 1'b0,
                data: 32'd0, br: 1'b0, exp: 1'b0};
          rob_q.push_back(e);
          next_tag = (next_tag + 1) % D;
        end
      end
    end
  end

  task automatic idle();
    alloc_req = 1'b0; alloc_dst_addr = 5'd0; alloc_dst_wen = 1'b0;
    wb_en = 1'b0; wb_tag = 3'd0; wb_data = 32'd0; wb_br_taken = 1'b0; wb_exp = 1'b0;
    rd_tag = 3'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic [TW-1:0] t, input logic [DW-1:0] d);
    wb_en = 1'b1; wb_tag = t; wb_data = d; wb_br_taken = 1'b0; wb_exp = 1'b0;
  endtask

  int            order [D] = '{3, 4, 5, 6, 7, 0, 1, 2};
  logic [DW-1:0] wd    [D];

  initial begin
    // Reset state: allocate_en follows alloc_req, buffer empty, no commit.
    rst = 1'b1;
    idle();
    alloc_req = 1'b1;
    #2;
    chk("rst_allocate_en", allocate_en, 1);
    chk("rst_empty", rob_empty, 1);
    chk("rst_full", rob_full, 0);
    chk("rst_commit", {commit_dst_en, rob_commit_br_taken, rob_commit_exp_en}, 0);
    step();
    step();
    rst = 1'b0;

    // Fill: tags 0..7, then the 9th request is refused.
    for (int i = 0; i < D; i++) begin
      idle();
      alloc_req = 1'b1; alloc_dst_addr = 5'(i + 1); alloc_dst_wen = 1'b1;
      #1;
      chk("fill_alloc_en", allocate_en, 1);
      chk("fill_tag", rob_alloc_tag_2rat, i);
      step();
    end
    #1;
    chk("full_after_8", rob_full, 1);
    chk("ninth_refused", allocate_en, 0);
    step();

    // Out-of-order writeback 2,0,1 retires in order 0,1,2.
    idle(); set_wb(3'd2, 32'hA2); step();
    idle(); set_wb(3'd0, 32'hA0); step();
    idle(); set_wb(3'd1, 32'hA1); #1;
    chk("c0_paddr", rob_commit_Paddr, 0);
    chk("c0_data", rob_commit_data, 32'hA0);
    chk("c0_dst_en", commit_dst_en, 1);
    chk("c0_dst", rob_commit_dst_addr_2rat, 1);
    step();
    idle(); #1;
    chk("c1_paddr", rob_commit_Paddr, 1);
    chk("c1_data", rob_commit_data, 32'hA1);
    step();
    idle(); #1;
    chk("c2_paddr", rob_commit_Paddr, 2);
    chk("c2_data", rob_commit_data, 32'hA2);
    chk("c2_dst", rob_commit_dst_addr_2rat, 3);
    step();
    idle(); #1;
    chk("head3_not_done", commit_dst_en, 0);

    // Refill across the wrap: tags 0,1,2 reused, tag 0 without a destination.
    for (int i = 0; i < 3; i++) begin
      idle();
      alloc_req = 1'b1; alloc_dst_addr = 5'(20 + i); alloc_dst_wen = (i != 0);
      #1;
      chk("wrap_tag", rob_alloc_tag_2rat, i);
      step();
    end
    idle(); #1;
    chk("wrap_full", rob_full, 1);

    // Drain in order; each commit trails its writeback by one cycle.
    for (int j = 0; j <= D; j++) begin
      idle();
      if (j < D) begin
        wd[j] = $urandom();
        set_wb(3'(order[j]), wd[j]);
      end
      #1;
      if (j > 0) begin
        chk("drain_paddr", rob_commit_Paddr, order[j-1]);
        chk("drain_data", rob_commit_data, wd[j-1]);
        chk("drain_dst_en", commit_dst_en, order[j-1] != 0);
      end else begin
        chk("drain_none", rob_commit_Paddr, 0);
      end
      step();
    end
    idle(); #1;
    chk("drain_empty", rob_empty, 1);
    step();

    // Branch redirect flush with concurrent allocation and writeback.
    idle(); alloc_req = 1'b1; alloc_dst_addr = 5'd10; alloc_dst_wen = 1'b1; #1;
    chk("br_tag_a", rob_alloc_tag_2rat, 3);
    step();
    idle(); alloc_req = 1'b1; alloc_dst_addr = 5'd11; alloc_dst_wen = 1'b1; #1;
    chk("br_tag_b", rob_alloc_tag_2rat, 4);
    step();
    idle(); set_wb(3'd3, 32'h55); wb_br_taken = 1'b1; step();
    idle(); alloc_req = 1'b1; set_wb(3'd4, 32'h66); #1;
    chk("br_commit", rob_commit_br_taken, 1);
    chk("br_alloc_blocked", allocate_en, 0);
    chk("br_paddr", rob_commit_Paddr, 3);
    step();
    idle(); #1;
    chk("br_empty", rob_empty, 1);
    chk("br_next_tag", rob_alloc_tag_2rat, 0);
    chk("br_one_cycle", rob_commit_br_taken, 0);
    step();

    // Exception flush blocks the register write and outranks the branch flag.
    idle(); alloc_req = 1'b1; alloc_dst_addr = 5'd9; alloc_dst_wen = 1'b1; #1;
    chk("exp_tag", rob_alloc_tag_2rat, 0);
    step();
    idle(); set_wb(3'd0, 32'h77); wb_exp = 1'b1; wb_br_taken = 1'b1; step();
    idle(); #1;
    chk("exp_en", rob_commit_exp_en, 1);
    chk("exp_no_dst", commit_dst_en, 0);
    chk("exp_no_br", rob_commit_br_taken, 0);
    step();
    idle(); #1;
    chk("exp_empty", rob_empty, 1);
    step();

    // Random traffic with two mid-cycle asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      idle();
      alloc_req      = ($urandom_range(0, 3) != 0);
      alloc_dst_addr = 5'($urandom());
      alloc_dst_wen  = 1'($urandom());
      wb_en          = 1'($urandom_range(0, 1));
      wb_tag         = 3'($urandom());
      wb_data        = $urandom();
      wb_br_taken    = ($urandom_range(0, 15) == 0);
      wb_exp         = ($urandom_range(0, 19) == 0);
      rd_tag         = 3'($urandom());
      if (c == 1500 || c == 2600) begin
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_empty", rob_empty, 1);
        chk("midrst_full", rob_full, 0);
        chk("midrst_rd_done", rd_done, 0);
        chk("midrst_commit", {commit_dst_en, rob_commit_br_taken, rob_commit_exp_en}, 0);
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
